reg_file_sequencer: RTL
=======================

REG_FILE_SEQUENCER -- requirements
Module: reg_file_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, register-file address width.
REQ-002 SHALL have parameter DATA_W, default 8, register-file data width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-005 SHALL have port start  input  1  command strobe, sampled only in IDLE.
REQ-006 SHALL have port op  input  2  opcode: 0 FILL, 1 COPY, 2 SWAP, 3 reserved.
REQ-007 SHALL have port src_base  input  ADDR_W  source / first-range base address.
REQ-008 SHALL have port dst_base  input  ADDR_W  destination / second-range base address.
REQ-009 SHALL have port len  input  ADDR_W  element count; 0 = no-op.
REQ-010 SHALL have port fill_value  input  DATA_W  data for FILL.
REQ-011 SHALL have port busy  output  1  high while a command executes.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port error  output  1  one-cycle pulse with done when op=3.
REQ-014 SHALL have ports rf_r1_addr, rf_r2_addr  output  ADDR_W each  register-file read addresses.
REQ-015 SHALL have ports rf_r1_out, rf_r2_out  input  DATA_W each  register-file read data, combinational from the read addresses.
REQ-016 SHALL have ports rf_write_addr  output  ADDR_W,  rf_write_data  output  DATA_W,  rf_write  output  1  write port; the register file writes on the rising edge where rf_write=1.

Function
REQ-017 SHALL implement states IDLE, FILL, COPY, SWAP_A, SWAP_B, DONE.
REQ-018 SHALL, in IDLE with start=1, latch op, bases, len and fill_value, clear element counter i, and go to the op state (DONE if len=0 or op=3) next cycle.
REQ-019 SHALL ignore start whenever busy=1; latched operands are not disturbed.
REQ-020 SHALL drive busy=1 in every state except IDLE.
REQ-021 FILL: one write per cycle, rf_write_addr=dst_base+i, rf_write_data=fill_value, for i=0..len-1.
REQ-022 COPY: one element per cycle, rf_r1_addr=src+k, rf_write_addr=dst+k, rf_write_data=rf_r1_out, same cycle.
REQ-023 COPY SHALL use k=i (ascending) when dst_base<=src_base and k=len-1-i (descending) when dst_base>src_base, so overlapping ranges copy correctly.
REQ-024 SWAP_A: rf_r1_addr=src+i, rf_r2_addr=dst+i; latch rf_r1_out into a holding register; write rf_r2_out to src+i.
REQ-025 SWAP_B: write the holding register to dst+i, increment i; two cycles per element, elements processed in ascending i.
REQ-026 SHALL compute all addresses modulo 2^ADDR_W (wrap 255 -> 0 at default width).
REQ-027 SHALL go to DONE the cycle after the final write; DONE asserts done=1 for exactly one cycle, error=1 with it if op=3, then returns to IDLE.
REQ-028 SHALL drive rf_write=0 in IDLE and DONE; in IDLE and DONE the address and data outputs SHALL be 0.
REQ-029 Total cycles start-sample to done: FILL/COPY len+1, SWAP 2*len+1, len=0 or op=3: 1.
REQ-030 A new start SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-031 Reset SHALL force IDLE, i=0, holding register=0, busy=0, done=0, error=0, rf_write=0, all address/data outputs 0.
REQ-032 Reset during any active state SHALL abort the command at that edge: no further writes, no done pulse; writes already committed remain.
REQ-033 Reset asserted together with start SHALL take priority; start is discarded.

Verification
REQ-034 FILL src=x dst=10 len=4 fill=0x55 -> regs 10..13=0x55, reg 14 untouched, done 5 cycles after start sample, busy high for those cycles.
REQ-035 COPY with regs 20..23=1,2,3,4, src=20 dst=22 len=4 -> regs 22..25=1,2,3,4 (descending order observed on rf_write_addr: 25,24,23,22).
REQ-036 SWAP src=0 dst=100 len=2, reg0=0xAA reg1=0xBB reg100=0x11 reg101=0x22 -> reg0=0x11 reg1=0x22 reg100=0xAA reg101=0xBB, done after 5 cycles.
REQ-037 FILL dst=254 len=3 fill=0x0F -> regs 254,255,0 written; reg 1 untouched.
REQ-038 len=0 or op=3 -> no rf_write pulses, done next cycle, error=1 only for op=3; start pulsed mid-FILL is ignored.
REQ-039 Reset asserted on 3rd write of FILL len=8 -> exactly 2 writes committed, rf_write=0 and busy=0 after the reset edge, no done pulse.

Source files
------------

// File: rtl/reg_file_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_sequencer
//  Purpose  : Block-operation sequencer driving an external register file.
//             Executes FILL, COPY (overlap-safe) and SWAP over address
//             ranges, one register-file access step per clock.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          sole clock, rising edge
//    reset          synchronous active-high reset
//    start          command strobe (sampled only while idle)
//    op             0 FILL, 1 COPY, 2 SWAP, 3 reserved (completes with error)
//    src_base       source / first-range base address
//    dst_base       destination / second-range base address
//    len            element count, 0 = no-op
//    fill_value     data written by FILL
//    busy           high while a command executes
//    done           one-cycle completion pulse
//    error          pulses with done for the reserved opcode
//    rf_r1_addr     register-file read port 1 address
//    rf_r2_addr     register-file read port 2 address
//    rf_r1_out      read port 1 data (combinational from rf_r1_addr)
//    rf_r2_out      read port 2 data (combinational from rf_r2_addr)
//    rf_write_addr  write port address
//    rf_write_data  write port data
//    rf_write       write enable, committed on the rising edge
// ============================================================================
module reg_file_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] rf_r1_addr,
  output logic [ADDR_W-1:0] rf_r2_addr,
  input  logic [DATA_W-1:0] rf_r1_out,
  input  logic [DATA_W-1:0] rf_r2_out,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write
);

  localparam logic [1:0] c_op_fill = 2'd0;
  localparam logic [1:0] c_op_copy = 2'd1;
  localparam logic [1:0] c_op_swap = 2'd2;
  localparam logic [1:0] c_op_rsvd = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_COPY   = 3'd2,
    S_SWAP_A = 3'd3,
    S_SWAP_B = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W-1:0]   r_len;
  logic [DATA_W-1:0]   r_fill;
  logic [ADDR_W-1:0]   r_i;
  logic [DATA_W-1:0]   r_hold;
  logic                r_desc;     // COPY walks the range top-down

  logic                w_last;
  logic [ADDR_W-1:0]   w_elem;
  logic                w_write;

  // Active states are only entered with len >= 1, so len-1 never underflows
  // while this is being used.
  assign w_last = (r_i == (r_len - ADDR_W'(1)));

  // Element index for COPY: descending when the destination lies above the
  // source so that an overlapping source element is read before it is
  // overwritten.
  assign w_elem = r_desc ? (r_len - ADDR_W'(1) - r_i) : r_i;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_i     <= '0;
      r_hold  <= '0;
      r_desc  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_src  <= src_base;
            r_dst  <= dst_base;
            r_len  <= len;
            r_fill <= fill_value;
            r_i    <= '0;
            r_desc <= (dst_base > src_base);
          end
        end
        S_FILL, S_COPY, S_SWAP_B: r_i    <= r_i + ADDR_W'(1);
        S_SWAP_A:                 r_hold <= rf_r1_out;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((len == '0) || (op == c_op_rsvd)) begin
            w_next_state = S_DONE;
          end else begin
            case (op)
              c_op_fill: w_next_state = S_FILL;
              c_op_copy: w_next_state = S_COPY;
              c_op_swap: w_next_state = S_SWAP_A;
              default:   w_next_state = S_DONE;
            endcase
          end
        end
      end
      S_FILL, S_COPY: if (w_last) w_next_state = S_DONE;
      S_SWAP_A:       w_next_state = S_SWAP_B;
      S_SWAP_B:       w_next_state = w_last ? S_DONE : S_SWAP_A;
      S_DONE:         w_next_state = S_IDLE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: everything is zero unless the state drives it
  // --------------------------------------------------------------------------
  always_comb begin
    rf_r1_addr    = '0;
    rf_r2_addr    = '0;
    rf_write_addr = '0;
    rf_write_data = '0;
    w_write       = 1'b0;
    case (r_state)
      S_FILL: begin
        rf_write_addr = r_dst + r_i;
        rf_write_data = r_fill;
        w_write       = 1'b1;
      end
      S_COPY: begin
        rf_r1_addr    = r_src + w_elem;
        rf_write_addr = r_dst + w_elem;
        rf_write_data = rf_r1_out;
        w_write       = 1'b1;
      end
      S_SWAP_A: begin
        rf_r1_addr    = r_src + r_i;
        rf_r2_addr    = r_dst + r_i;
        rf_write_addr = r_src + r_i;
        rf_write_data = rf_r2_out;
        w_write       = 1'b1;
      end
      S_SWAP_B: begin
        rf_write_addr = r_dst + r_i;
        rf_write_data = r_hold;
        w_write       = 1'b1;
      end
      default: ;
    endcase
  end

  // A reset in an active cycle aborts the command at that edge, so the write
  // that would otherwise commit on the same edge is suppressed.
  assign rf_write = w_write & ~reset;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign error    = (r_state == S_DONE) && (r_op == c_op_rsvd);

endmodule
`default_nettype wire
